// File: rtl/inport_pkg.sv
// Shared constants, flag record and flag-update rule for the inport block.
package inport_pkg;

  localparam int INPORT_WIDTH_DEFAULT = 32;
  localparam int INPORT_SYNC_STAGES   = 2;
  localparam logic [INPORT_WIDTH_DEFAULT-1:0] INPORT_RESET_VALUE = '0;

  // Handshake status kept alongside the captured value.
  typedef struct packed {
    logic valid;    // Q holds a capture the consumer has not acknowledged
    logic overrun;  // sticky: a capture replaced an unacknowledged value
  } inport_flags_t;

  // Next flag state for one clock, given whether a capture happens and
  // whether the consumer acknowledges in the same cycle. A capture always
  // wins over an acknowledge, so new data is never reported as consumed.
  function automatic inport_flags_t inport_next_flags(
    input inport_flags_t cur,
    input logic          capture,
    input logic          rd
  );
    inport_flags_t nxt;
    nxt = cur;
    if (capture && cur.valid && !rd) begin
      nxt.overrun = 1'b1;
    end
    if (capture) begin
      nxt.valid = 1'b1;
    end else if (rd) begin
      nxt.valid = 1'b0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/inport_sync.sv
// Flop chain synchronizer: STAGES registers deep, WIDTH bits wide, cleared
// asynchronously to zero. Used on the external strobe/data pins when the
// port is driven from another clock domain.
module inport_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift the input through the chain; reset empties every stage.
  // NOTE: every stage is reset, not just the last one, so no stale pre-reset
  // sample can ripple out as a phantom capture after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old value
      // of its neighbour, giving a true shift instead of a pass-through.
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign dout = chain[STAGES-1];

endmodule

// File: rtl/inport.sv
// Registered input port with valid/overrun handshake.
// Captures D into Q on every clock where strobe is high; valid marks an
// unacknowledged capture, overrun is a sticky flag for lost data.
// Build option: define INPORT_SYNC_EN to route strobe and D through an
// INPORT_SYNC_STAGES-deep synchronizer (latency becomes stages+1 clocks).
// The parent should tie rd to 0 when there is no consumer acknowledge.
module inport
  import inport_pkg::*;
#(
  parameter int               WIDTH       = INPORT_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(INPORT_RESET_VALUE)
) (
  input  logic             clr,
  input  logic             clk,
  input  logic             strobe,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  input  logic             rd,
  output logic             valid,
  output logic             overrun
);

  logic             s_e;
  logic [WIDTH-1:0] d_e;

`ifdef INPORT_SYNC_EN
  logic [WIDTH:0] sync_out;

  // Strobe and data share one chain so they stay aligned cycle for cycle.
  inport_sync #(
    .WIDTH  (WIDTH + 1),
    .STAGES (INPORT_SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (clr),
    .din   ({strobe, D}),
    .dout  (sync_out)
  );

  assign s_e = sync_out[WIDTH];
  assign d_e = sync_out[WIDTH-1:0];
`else
  assign s_e = strobe;
  assign d_e = D;
`endif

  inport_flags_t    flags;
  inport_flags_t    flags_next;
  logic [WIDTH-1:0] q_next;

  // Next-state: load on capture, otherwise hold; flags follow the shared rule.
  // NOTE: each output of an always_comb gets a value on every path (here a
  // single unconditional expression), which is what keeps latches out.
  always_comb begin
    q_next     = s_e ? d_e : Q;
    flags_next = inport_next_flags(flags, s_e, rd);
  end

  // State registers; Q comes straight from these flops, never from D.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      Q     <= RESET_VALUE;
      flags <= '0;
    end else begin
      Q     <= q_next;
      flags <= flags_next;
    end
  end

  assign valid   = flags.valid;
  assign overrun = flags.overrun;

endmodule

// File: tb/tb_inport.sv
// Self-checking bench for inport: directed scenarios followed by random
// traffic, compared against a queue-based behavioural model of the port.
module tb_inport;

`ifdef INPORT_SYNC_EN
  localparam int DELAY = 2;
`else
  localparam int DELAY = 0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic        strobe = 1'b0;
  logic [31:0] D = '0;
  logic        rd = 1'b0;
  logic [31:0] Q;
  logic        valid;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  inport #(.WIDTH(32), .RESET_VALUE(32'h0)) dut (
    .clr     (clr),
    .clk     (clk),
    .strobe  (strobe),
    .D       (D),
    .Q       (Q),
    .rd      (rd),
    .valid   (valid),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  // Reference model: inputs seen DELAY edges ago take effect now.
  typedef struct packed {
    logic        s;
    logic [31:0] d;
  } samp_t;

  samp_t       pipe[$];
  logic [31:0] m_q;
  logic        m_valid;
  logic        m_over;

  task automatic model_reset();
    samp_t z;
    z = '0;
    m_q     = 32'h0;
    m_valid = 1'b0;
    m_over  = 1'b0;
    pipe.delete();
    for (int i = 0; i < DELAY; i++) pipe.push_back(z);
  endtask

  task automatic model_edge();
    samp_t cur;
    samp_t e;
    cur.s = strobe;
    cur.d = D;
    pipe.push_back(cur);
    e = pipe.pop_front();
    if (e.s && m_valid && !rd) m_over = 1'b1;
    if (e.s) begin
      m_q     = e.d;
      m_valid = 1'b1;
    end else if (rd) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_q"},       Q,                m_q);
    check({tag, "_valid"},   {31'h0, valid},   {31'h0, m_valid});
    check({tag, "_overrun"}, {31'h0, overrun}, {31'h0, m_over});
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (clr) model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset held with all-ones data and strobe high: nothing may load.
    strobe = 1'b1;
    D      = 32'hFFFF_FFFF;
    rd     = 1'b0;
    clr    = 1'b0;
    model_reset();
    #1;
    check_all("rst_init");
    repeat (2) cycle("rst_hold");
    check("rst_q_zero", Q, 32'h0);

    // Release reset with constant D=2 and strobe high, never acknowledged.
    clr = 1'b1;
    D   = 32'h2;
    repeat (DELAY + 3) cycle("const2");
    check("const2_q",       Q,                32'h2);
    check("const2_overrun", {31'h0, overrun}, 32'h1);

    // Clear the sticky overrun.
    clr = 1'b0;
    #1;
    model_reset();
    check_all("rst2");
    #1;
    clr = 1'b1;

    // Single-cycle capture; later data changes must not reach Q.
    strobe = 1'b1;
    D      = 32'h1234_5678;
    cycle("hold_cap");
    strobe = 1'b0;
    D      = 32'hDEAD_BEEF;
    repeat (DELAY + 3) cycle("hold");
    check("hold_q", Q, 32'h1234_5678);

    // Acknowledge without a capture clears valid only.
    rd = 1'b1;
    cycle("ack");
    rd = 1'b0;
    cycle("ack_after");
    check("ack_valid",   {31'h0, valid},   32'h0);
    check("ack_overrun", {31'h0, overrun}, 32'h0);

    // Acknowledge on the very edge that captures: valid stays set.
    for (int i = 0; i <= DELAY; i++) begin
      strobe = (i == 0);
      if (i == 0) D = $urandom;
      rd = (i == DELAY);
      cycle("cap_rd");
    end
    rd     = 1'b0;
    strobe = 1'b0;
    check("cap_rd_valid",   {31'h0, valid},   32'h1);
    check("cap_rd_overrun", {31'h0, overrun}, 32'h0);

    // Asynchronous reset between edges while Q holds a pattern.
    strobe = 1'b1;
    D      = 32'hA5A5_A5A5;
    cycle("a5_cap");
    strobe = 1'b0;
    repeat (DELAY) cycle("a5_wait");
    check("a5_q", Q, 32'hA5A5_A5A5);
    #3;
    clr = 1'b0;
    #1;
    model_reset();
    check("async_q",       Q,                32'h0);
    check("async_valid",   {31'h0, valid},   32'h0);
    check("async_overrun", {31'h0, overrun}, 32'h0);
    #1;
    clr = 1'b1;

    // Random traffic with occasional mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      strobe = ($urandom_range(0, 2) == 0);
      rd     = ($urandom_range(0, 3) == 0);
      D      = $urandom;
      cycle("rand");
      if ($urandom_range(0, 59) == 0) begin
        #2;
        clr = 1'b0;
        #1;
        model_reset();
        check_all("rand_rst");
        #1;
        clr = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
